// File: rtl/patchembed_token_streamer.sv
// Streams patchembed's per-channel result planes out as requantized 8-bit tokens.
// One token (all channels of one output pixel) per valid/ready beat, in raster order.
module patchembed_token_streamer #(
    parameter int sum_width    = 30,
    parameter int out_channels = 64,
    parameter int out_size     = 27,
    parameter int out_bw       = 8,
    parameter int shift_width  = 5,
    localparam int ntok        = out_size * out_size,
    localparam int aw          = $clog2(out_channels),
    localparam int iw          = $clog2(ntok)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           src_done,
    input  logic [shift_width-1:0]         shift,
    output logic [aw-1:0]                  out_addr,
    input  logic [ntok*sum_width-1:0]      data_out,
    output logic                           tok_valid,
    input  logic                           tok_ready,
    output logic [out_channels*out_bw-1:0] tok_data,
    output logic [iw-1:0]                  tok_idx,
    output logic                           tok_last,
    output logic                           busy,
    output logic                           done,
    output logic [15:0]                    sat_count,
    output logic [2:0]                     dbg_state
);

    // Token stream: a beat transfers on any clock edge where tok_valid & tok_ready;
    // tok_data/tok_idx/tok_last hold steady from tok_valid rising until that edge.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SRC = 3'd1,
        GATHER   = 3'd2,
        EMIT     = 3'd3,
        FINISH   = 3'd4
    } state_t;

    localparam int kw = $clog2(out_channels + 1);
    localparam logic [kw-1:0] k_end      = kw'(out_channels);
    localparam logic [kw-1:0] k_last_adr = kw'(out_channels - 1);
    // Wide enough that x + 2^(s-1) never wraps, even for the largest shift.
    localparam int ew = ((sum_width > (1 << shift_width)) ? sum_width : (1 << shift_width)) + 2;
    localparam logic signed [ew-1:0] max_v = ew'(2 ** (out_bw - 1) - 1);
    localparam logic signed [ew-1:0] min_v = -max_v - ew'(1);

    state_t                          state_q;
    logic [kw-1:0]                   k_q;
    logic [shift_width-1:0]          shift_q;
    logic [aw-1:0]                   out_addr_q;
    logic [out_channels*out_bw-1:0]  tok_data_q;
    logic [iw-1:0]                   tok_idx_q;
    logic                            tok_valid_q;
    logic                            tok_last_q;
    logic                            busy_q;
    logic                            done_q;
    logic [15:0]                     sat_q;

    logic signed [sum_width-1:0] elem;
    logic signed [ew-1:0]        ext;
    logic signed [ew-1:0]        rnd;
    logic signed [ew-1:0]        shifted;
    logic [out_bw-1:0]           rq;
    logic                        sat;

    // data_out carries the plane addressed last cycle, so lane k-1 is filled at step k.
    always_comb begin
        elem    = data_out[int'(tok_idx_q)*sum_width +: sum_width];
        ext     = ew'(elem);
        rnd     = '0;
        if (shift_q != '0) begin
            rnd[shift_q - 1'b1] = 1'b1;
        end
        shifted = (ext + rnd) >>> shift_q;
        sat     = 1'b0;
        if (shifted > max_v) begin
            rq  = max_v[out_bw-1:0];
            sat = 1'b1;
        end else if (shifted < min_v) begin
            rq  = min_v[out_bw-1:0];
            sat = 1'b1;
        end else begin
            rq  = shifted[out_bw-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            shift_q     <= '0;
            out_addr_q  <= '0;
            tok_data_q  <= '0;
            tok_idx_q   <= '0;
            tok_valid_q <= 1'b0;
            tok_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q    <= shift;
                        sat_q      <= '0;
                        busy_q     <= 1'b1;
                        tok_idx_q  <= '0;
                        k_q        <= '0;
                        out_addr_q <= '0;
                        state_q    <= src_done ? GATHER : WAIT_SRC;
                    end
                end
                WAIT_SRC: begin
                    if (src_done) begin
                        state_q <= GATHER;
                    end
                end
                GATHER: begin
                    if (k_q < k_last_adr) begin
                        out_addr_q <= out_addr_q + aw'(1);
                    end
                    if (k_q != '0) begin
                        tok_data_q[(int'(k_q) - 1)*out_bw +: out_bw] <= rq;
                        if (sat && sat_q != 16'hffff) begin
                            sat_q <= sat_q + 16'd1;
                        end
                    end
                    if (k_q == k_end) begin
                        state_q     <= EMIT;
                        tok_valid_q <= 1'b1;
                        tok_last_q  <= (tok_idx_q == iw'(ntok - 1));
                    end else begin
                        k_q <= k_q + kw'(1);
                    end
                end
                EMIT: begin
                    if (tok_ready) begin
                        tok_valid_q <= 1'b0;
                        tok_last_q  <= 1'b0;
                        if (tok_last_q) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            tok_idx_q  <= tok_idx_q + iw'(1);
                            k_q        <= '0;
                            out_addr_q <= '0;
                            state_q    <= GATHER;
                        end
                    end
                end
                FINISH: begin
                    tok_idx_q <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_addr  = out_addr_q;
    assign tok_valid = tok_valid_q;
    assign tok_data  = tok_data_q;
    assign tok_idx   = tok_idx_q;
    assign tok_last  = tok_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_count = sat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_patchembed_token_streamer.sv
// Directed bench for patchembed_token_streamer: requant table, WAIT_SRC/abort,
// saturation ceiling and one full backpressured frame against a bench-side model.
module tb_patchembed_token_streamer;

    localparam int sw = 30;
    localparam int nc = 64;
    localparam int nt = 729;
    localparam int bw = 8;
    localparam int dw = nt * sw;
    localparam int tw = nc * bw;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          src_done = 1'b0;
    logic          tok_ready = 1'b0;
    logic [4:0]    shift = '0;
    logic [5:0]    out_addr;
    logic [dw-1:0] data_out = '0;
    logic          tok_valid;
    logic          tok_last;
    logic          busy;
    logic          done;
    logic [tw-1:0] tok_data;
    logic [9:0]    tok_idx;
    logic [15:0]   sat_count;
    logic [2:0]    dbg_state;

    logic [dw-1:0] planes [nc];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int x;
        int sh;
        int exp;
        int nsat;
    } vec_t;
    vec_t vecs [21];

    patchembed_token_streamer dut (
        .clk(clk), .reset(reset), .start(start), .src_done(src_done), .shift(shift),
        .out_addr(out_addr), .data_out(data_out), .tok_valid(tok_valid),
        .tok_ready(tok_ready), .tok_data(tok_data), .tok_idx(tok_idx),
        .tok_last(tok_last), .busy(busy), .done(done), .sat_count(sat_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Source plane memory with one cycle of read latency.
    always @(posedge clk) data_out <= planes[out_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [tw-1:0] act, input logic [tw-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_unity();
        for (int c = 0; c < nc; c++)
            for (int t = 0; t < nt; t++)
                planes[c][t*sw +: sw] = sw'(c*1000 + t);
    endtask

    task automatic fill_const(input int x);
        for (int c = 0; c < nc; c++)
            for (int t = 0; t < nt; t++)
                planes[c][t*sw +: sw] = sw'(x);
    endtask

    function automatic logic [tw-1:0] exp_unity(input int t);
        logic [tw-1:0] r;
        int v;
        r = '0;
        for (int c = 0; c < nc; c++) begin
            v = c*1000 + t;
            if (v > 127) v = 127;
            r[c*bw +: bw] = bw'(v);
        end
        return r;
    endfunction

    function automatic int unity_sat_total();
        int n;
        n = 0;
        for (int t = 0; t < nt; t++)
            for (int c = 0; c < nc; c++)
                if (c*1000 + t > 127) n++;
        return n;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic start_frame(input logic [4:0] sh, input logic sd);
        shift    = sh;
        src_done = sd;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Edges waited for tok_valid; 300 means the bound expired.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!tok_valid && edges < 300) begin
            step();
            edges++;
        end
    endtask

    function automatic logic [tw-1:0] status_word();
        return tw'({out_addr, tok_valid, tok_idx, tok_last, busy, done, sat_count, dbg_state});
    endfunction

    initial begin
        int e, hs, gap, guard, n_last, n_done;
        logic fresh, prev_stall, hs_now, ok_hold;
        logic [tw-1:0] pdata;
        logic [9:0] pidx;
        logic [7:0] e8;

        vecs = '{
            '{0, 0, 0, 0},           '{100, 0, 100, 0},        '{127, 0, 127, 0},
            '{128, 0, 127, 64},      '{-128, 0, -128, 0},      '{-129, 0, -128, 64},
            '{24, 4, 2, 0},          '{23, 4, 1, 0},           '{-24, 4, -1, 0},
            '{-25, 4, -2, 0},        '{5000, 4, 127, 64},      '{-5000, 4, -128, 64},
            '{536870911, 0, 127, 64}, '{-536870912, 0, -128, 64}, '{536870911, 29, 1, 0},
            '{-536870912, 29, -1, 0}, '{40, 3, 5, 0},           '{-20, 3, -2, 0},
            '{2039, 4, 127, 0},      '{2040, 4, 127, 64},      '{-1, 1, 0, 0}
        };

        // Reset state
        reset = 1'b0;
        step();
        step();
        check("reset_status", status_word(), '0);
        check("reset_tok_data", tok_data, '0);
        reset = 1'b1;
        step();
        check("idle_status", status_word(), '0);

        // Requant table: every element of every plane = x, so all lanes of token 0 match.
        tok_ready = 1'b1;
        for (int i = 0; i < $size(vecs); i++) begin
            fill_const(vecs[i].x);
            start_frame(5'(vecs[i].sh), 1'b1);
            wait_valid(e);
            e8 = bw'(vecs[i].exp);
            check($sformatf("vec%0d_latency", i), tw'(e), tw'(65));
            check($sformatf("vec%0d_lane0", i), tw'(tok_data[7:0]), tw'(e8));
            check($sformatf("vec%0d_lane63", i), tw'(tok_data[tw-1 -: 8]), tw'(e8));
            check($sformatf("vec%0d_sat", i), tw'(sat_count), tw'(vecs[i].nsat));
            check($sformatf("vec%0d_idx", i), tw'(tok_idx), '0);
            do_reset();
        end

        // WAIT_SRC with an ignored second start, then abort mid-GATHER of token 5
        fill_unity();
        start_frame(5'd0, 1'b0);
        check("ws_state", tw'({dbg_state, busy}), tw'({3'd1, 1'b1}));
        ok_hold = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                start = 1'b1;
                shift = 5'd4;
            end
            step();
            start = 1'b0;
            if (out_addr != '0 || tok_valid || dbg_state != 3'd1) ok_hold = 1'b0;
        end
        check("ws_hold", tw'(ok_hold), tw'(1));
        src_done = 1'b1;
        step();
        src_done = 1'b0;
        check("ws_gather", tw'({dbg_state, out_addr}), tw'({3'd2, 6'd0}));
        step();
        check("ws_sweep", tw'(out_addr), tw'(1));
        wait_valid(e);
        check("ws_latency", tw'(e + 1), tw'(65));
        check("ws_data0", tok_data, exp_unity(0));
        check("ws_sat0", tw'(sat_count), tw'(63));
        for (int t = 0; t < 4; t++) begin
            check("ws_idx", tw'(tok_idx), tw'(t));
            step();
            wait_valid(e);
            check("ws_gap", tw'(e), tw'(65));
            check("ws_data", tok_data, exp_unity(t + 1));
        end
        step();
        for (int i = 0; i < 10; i++) step();
        check("abort_pre", tw'({dbg_state, tok_idx}), tw'({3'd2, 10'd5}));
        reset = 1'b0;
        #1;
        check("abort_status", status_word(), '0);
        check("abort_tok_data", tok_data, '0);
        step();
        reset = 1'b1;
        step();
        start_frame(5'd0, 1'b1);
        wait_valid(e);
        check("restart_latency", tw'(e), tw'(65));
        check("restart_idx", tw'(tok_idx), '0);
        check("restart_data", tok_data, exp_unity(0));
        do_reset();

        // Saturation at the top of the 30-bit range
        fill_const(536870911);
        start_frame(5'd0, 1'b1);
        for (int t = 0; t < 3; t++) begin
            wait_valid(e);
            check("ceil_data", tok_data, {nc{8'h7f}});
            check("ceil_sat", tw'(sat_count), tw'(64 * (t + 1)));
            step();
        end
        do_reset();

        // Full frame with random backpressure
        fill_unity();
        tok_ready = 1'b1;
        start_frame(5'd0, 1'b1);
        gap = 0; hs = 0; guard = 0; n_last = 0; n_done = 0;
        fresh = 1'b1; prev_stall = 1'b0; pdata = '0; pidx = '0;
        while (hs < nt && guard < 70000) begin
            if (prev_stall) begin
                check("stall_idx", tw'({tok_valid, tok_idx}), tw'({1'b1, pidx}));
                check("stall_data", tok_data, pdata);
            end
            prev_stall = 1'b0;
            hs_now = 1'b0;
            if (tok_valid) begin
                if (fresh) begin
                    check("ff_gap", tw'(gap), tw'(65));
                    check("ff_idx", tw'(tok_idx), tw'(hs));
                    check("ff_data", tok_data, exp_unity(hs));
                    check("ff_last", tw'(tok_last), tw'(hs == nt - 1));
                    if (tok_last) n_last++;
                    fresh = 1'b0;
                end
                tok_ready = (hs == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (tok_ready) begin
                    hs++;
                    fresh  = 1'b1;
                    hs_now = 1'b1;
                end else begin
                    prev_stall = 1'b1;
                    pdata = tok_data;
                    pidx  = tok_idx;
                end
            end
            if (done) n_done++;
            step();
            guard++;
            gap = hs_now ? 0 : gap + 1;
        end
        check("ff_handshakes", tw'(hs), tw'(nt));
        check("ff_last_count", tw'(n_last), tw'(1));
        check("ff_early_done", tw'(n_done), '0);
        check("ff_done", tw'({done, busy, tok_valid, dbg_state}), tw'({1'b1, 1'b1, 1'b0, 3'd4}));
        step();
        check("ff_idle", tw'({done, busy, tok_idx, dbg_state}), tw'({1'b0, 1'b0, 10'd0, 3'd0}));
        check("ff_sat", tw'(sat_count), tw'(unity_sat_total()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
